act_packer: RTL

ACT_PACKER -- requirements
Module: act_packer

---
 rtl/act_packer_if.sv | 22 ++
 rtl/act_packer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/act_packer_if.sv
// Stream bundle between the activation source, the packer and the next layer.
// The slave modport is the packer's view (accepts beats, produces words);
// the master modport is the view of the block that feeds and drains it.
interface act_packer_if;
    logic [63:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [11:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;

    modport master (
        output s_tdata, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast
    );

    modport slave (
        input  s_tdata, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/act_packer.sv
// Activation packer: gathers three 4-bit activation beats (one per image)
// into a 12-bit word {img2, img1, img0}, tags the last word of each frame of
// NUM_NEURONS words and buffers words in a first-word-fallthrough FIFO.
module act_packer #(
    parameter int NUM_NEURONS = 16,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic          CLK,
    input  logic          RST,
    act_packer_if.slave   bus,
    input  logic          flush,
    output logic [1:0]    status,
    output logic          frame_done
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        LANE0 = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2
    } lane_t;

    lane_t         lane, lane_nxt;
    logic [IW-1:0] widx;
    logic [7:0]    hold;
    logic [12:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, occ;
    logic          full, empty;
    logic          rdy_en;
    logic          beat_acc, push, pop;
    logic [12:0]   head;
    logic          unused_hi;

    // Only the low nibble of a beat carries an activation.
    assign unused_hi = ^bus.s_tdata[63:4];

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign occ   = wr_ptr - rd_ptr;
    assign full  = (occ == DEPTH_C);
    assign empty = (occ == '0);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Readiness depends on registered fullness only; a pop in the same cycle
    // does not open room for the completing beat.
    assign bus.s_tready = rdy_en & ~flush & ((lane != LANE2) | ~full);
    assign beat_acc     = bus.s_tvalid & bus.s_tready;
    assign push         = beat_acc & (lane == LANE2);
    assign pop          = ~empty & bus.m_tready & ~flush;

    assign bus.m_tvalid = ~empty;
    assign bus.m_tdata  = empty ? 12'd0 : head[11:0];
    assign bus.m_tlast  = ~empty & head[12];

    // Status: full dominates, then an in-progress frame, then buffered words.
    always_comb begin
        status = 2'b00;
        if (full)
            status = 2'b11;
        else if ((lane != LANE0) || (widx != '0))
            status = 2'b01;
        else if (!empty)
            status = 2'b10;
    end

    // Lane next-state: advance on each accepted beat, flush returns to lane 0.
    always_comb begin
        lane_nxt = lane;
        if (flush) begin
            lane_nxt = LANE0;
        end else if (beat_acc) begin
            unique case (lane)
                LANE0:   lane_nxt = LANE1;
                LANE1:   lane_nxt = LANE2;
                LANE2:   lane_nxt = LANE0;
                default: lane_nxt = LANE0;
            endcase
        end
    end

    // Lane state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            lane <= LANE0;
        else
            lane <= lane_nxt;
    end

    // Control state: word index, FIFO pointers, ready enable, frame pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            widx       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rdy_en     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            rdy_en     <= 1'b1;
            frame_done <= pop & head[12];
            if (flush) begin
                widx   <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    widx <= (widx == LAST_IDX) ? '0 : widx + 1'b1;
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Data path: partial-word hold register and FIFO storage (no reset needed,
    // outputs are gated by the empty flag).
    always_ff @(posedge CLK) begin
        if (flush) begin
            hold <= 8'd0;
        end else if (beat_acc) begin
            if (lane == LANE0)
                hold[3:0] <= bus.s_tdata[3:0];
            if (lane == LANE1)
                hold[7:4] <= bus.s_tdata[3:0];
        end
        if (push)
            mem[wr_ptr[AW-1:0]] <= {(widx == LAST_IDX), bus.s_tdata[3:0], hold};
    end

endmodule
